// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : fetch_pkg                                                      |
// | Purpose   : Shared types and default configuration for the instruction     |
// |             fetch front end (fetch_prefetch_queue / fetch_fifo).           |
// | Contents  : C_* default parameter values, fetch_entry_t queue entry type.  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package fetch_pkg;

    localparam int unsigned C_ADDR_W   = 16;
    localparam int unsigned C_INSTR_W  = 16;
    localparam int unsigned C_DEPTH    = 4;
    localparam int unsigned C_PC_STEP  = 2;
    localparam int unsigned C_RESET_PC = 0;

    // One queue entry at the default widths: the instruction and the PC it
    // was fetched from, so decode never has to reconstruct the PC.
    typedef struct packed {
        logic [C_ADDR_W-1:0]  pc;
        logic [C_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fetch_fifo                                                     |
// | Purpose   : DEPTH-entry circular queue holding fetched {pc, instr} words.  |
// |             Flush has priority over push and pop. Head is read            |
// |             combinationally (show-ahead).                                  |
// | Ports     : clk, rst_n       clock / async active-low reset                |
// |             flush            empty the queue, pointers to zero             |
// |             push, push_data  enqueue one entry                             |
// |             pop              dequeue the head entry                        |
// |             head_data        current head entry                            |
// |             head_valid       queue not empty                               |
// |             count            occupied entries                              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = push && !flush;
    assign w_do_pop  = pop && !w_empty && !flush;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: nothing is visible until head_valid is set.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head_data  = r_mem[r_rd_ptr];
    assign head_valid = !w_empty;
    assign count      = r_count;

    // The issuing side reserves a slot before every request, so an enqueue
    // into a full queue means the credit accounting is broken.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && w_full))
        else $error("fetch_fifo: enqueue while full");

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fetch_prefetch_queue                                           |
// | Purpose   : Instruction-fetch front end. Issues sequential PCs to a        |
// |             1-cycle-latency program memory and buffers the returned        |
// |             instructions with their PCs so decode can stall without        |
// |             re-fetching. Handles redirect (flush) and system halt.         |
// | Ports     : clk, rst_n                 clock / async active-low reset      |
// |             imem_req, imem_addr        program memory read request         |
// |             imem_data                  read data, 1 cycle after request    |
// |             redirect, redirect_pc      taken branch/jump from decode       |
// |             halt_sys                   freeze fetch and dequeue            |
// |             out_ready                  decode accepts head entry           |
// |             out_valid/instr/pc         head entry to decode                |
// |             count                      occupied queue entries              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = C_ADDR_W,
    parameter int unsigned INSTR_W  = C_INSTR_W,
    parameter int unsigned DEPTH    = C_DEPTH,
    parameter int unsigned PC_STEP  = C_PC_STEP,
    parameter int unsigned RESET_PC = C_RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]      imem_data,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_pc,
    input  logic                    halt_sys,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [ADDR_W-1:0]       out_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] C_START_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] C_STEP     = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic              r_inflight;
    logic              r_kill;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CNT_W:0]    w_credit;
    entry_t            w_push_entry;
    entry_t            w_head_entry;
    logic [ENTRY_W-1:0] w_head_raw;
    logic              w_head_valid;
    logic [CNT_W-1:0]  w_fifo_count;

    assign w_pop = w_head_valid && out_ready && !halt_sys;

    // Slots already taken, plus the one reserved by a request in flight,
    // plus the entry leaving this cycle; one extra bit so the sum cannot wrap.
    assign w_credit = (CNT_W+1)'(w_fifo_count)
                    + (CNT_W+1)'(r_inflight)
                    + (CNT_W+1)'(w_pop);

    // rst_n is folded in so the request stays low while reset is asserted
    // even though the rest of the term is purely combinational.
    assign w_issue = rst_n && !halt_sys && !redirect
                   && (w_credit < (CNT_W+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= C_START_PC;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_kill     <= r_inflight;
        end else begin
            r_kill     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_resp_pc  <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + C_STEP;
            end
        end
    end

    // The response is on imem_data during the cycle r_inflight is set and is
    // captured at the end of it. A redirect in that same cycle flushes the
    // queue, which takes priority inside the fifo, so the stale word is lost.
    assign w_push             = r_inflight && !r_kill;
    assign w_push_entry.pc    = r_resp_pc;
    assign w_push_entry.instr = imem_data;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (w_push),
        .push_data  (w_push_entry),
        .pop        (w_pop),
        .head_data  (w_head_raw),
        .head_valid (w_head_valid),
        .count      (w_fifo_count)
    );

    assign w_head_entry = entry_t'(w_head_raw);

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;
    assign out_valid = w_head_valid;
    // Empty queue presents zeros rather than whatever stale word sits at
    // the read pointer.
    assign out_instr = w_head_valid ? w_head_entry.instr : '0;
    assign out_pc    = w_head_valid ? w_head_entry.pc    : '0;
    assign count     = w_fifo_count;

endmodule : fetch_prefetch_queue
`default_nettype wire
